// File: rtl/game_score_keeper.sv
// -----------------------------------------------------------------------------
// game_score_keeper
//   Score and serve sequencer for a two-sided paddle game. Tracks the player
//   and enemy scores, pauses for a fixed number of video frames before each
//   serve, enables the ball only during play and flags the end of the game.
//
// Parameters
//   WIN_SCORE      points that end the game (1..9, scores stay one digit)
//   SERVE_FRAMES   frame ticks of pause before each serve (>= 1)
//   RESTART_FRAMES frame ticks spent in GAME_OVER before an automatic restart
//
// Ports
//   clk_i             system clock, rising edge
//   rst_i             synchronous active-high reset
//   frame_tick_i      one-cycle pulse per video frame
//   player_goal_i     one-cycle pulse, player scores
//   enemy_goal_i      one-cycle pulse, enemy scores
//   new_game_i        request a new game
//   player_score_o    binary player score
//   enemy_score_o     binary enemy score
//   ball_en_o         high only while in PLAY
//   serve_to_player_o next serve direction, 1 = toward player
//   game_over_o       high only while in GAME_OVER
//   player_won_o      winner while game_over_o, 1 = player
//
// Configuration
//   GAME_SCORE_AUTO_RESTART_EN  when defined, the RESTART_FRAMES-th frame tick
//   in GAME_OVER starts a new game; otherwise GAME_OVER holds until
//   new_game_i or rst_i and RESTART_FRAMES is unused.
// -----------------------------------------------------------------------------

package score_pkg;
  // Scores are a single decimal digit (0..9).
  localparam int MAX_SCORE_W = 4;
endpackage

module game_score_keeper
  import score_pkg::*;
#(
  parameter int WIN_SCORE      = 9,
  parameter int SERVE_FRAMES   = 60,
  parameter int RESTART_FRAMES = 180
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   frame_tick_i,
  input  logic                   player_goal_i,
  input  logic                   enemy_goal_i,
  input  logic                   new_game_i,
  output logic [MAX_SCORE_W-1:0] player_score_o,
  output logic [MAX_SCORE_W-1:0] enemy_score_o,
  output logic                   ball_en_o,
  output logic                   serve_to_player_o,
  output logic                   game_over_o,
  output logic                   player_won_o
);

  localparam int MAX_FRAMES = (SERVE_FRAMES > RESTART_FRAMES) ? SERVE_FRAMES : RESTART_FRAMES;
  localparam int CNT_W      = $clog2(MAX_FRAMES + 1);

  localparam logic [CNT_W-1:0]       SERVE_LAST   = CNT_W'(SERVE_FRAMES - 1);
  localparam logic [MAX_SCORE_W-1:0] WIN_VAL      = MAX_SCORE_W'(WIN_SCORE);
  localparam logic [MAX_SCORE_W-1:0] ONE          = MAX_SCORE_W'(1);

  typedef enum logic [1:0] {
    SERVE     = 2'd0,
    PLAY      = 2'd1,
    GAME_OVER = 2'd2
  } state_t;

  state_t                 state, state_nxt;
  logic [CNT_W-1:0]       cnt, cnt_nxt;
  logic [MAX_SCORE_W-1:0] p_score, p_score_nxt;
  logic [MAX_SCORE_W-1:0] e_score, e_score_nxt;
  logic                   serve_dir, serve_dir_nxt;
  logic                   won, won_nxt;
  logic                   restart;

  // Restart request: external, or the automatic timeout out of GAME_OVER.
`ifdef GAME_SCORE_AUTO_RESTART_EN
  localparam logic [CNT_W-1:0] RESTART_LAST = CNT_W'(RESTART_FRAMES - 1);
  assign restart = new_game_i ||
                   (state == GAME_OVER && frame_tick_i && cnt == RESTART_LAST);
`else
  assign restart = new_game_i;
`endif

  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the case leaves it unassigned, which would infer a latch.
    state_nxt     = state;
    cnt_nxt       = cnt;
    p_score_nxt   = p_score;
    e_score_nxt   = e_score;
    serve_dir_nxt = serve_dir;
    won_nxt       = won;

    if (restart) begin
      // A new game wins over any goal pulse in the same cycle.
      state_nxt     = SERVE;
      cnt_nxt       = '0;
      p_score_nxt   = '0;
      e_score_nxt   = '0;
      serve_dir_nxt = 1'b0;
      won_nxt       = 1'b0;
    end else begin
      unique case (state)
        SERVE: begin
          if (frame_tick_i) begin
            if (cnt == SERVE_LAST) begin
              state_nxt = PLAY;
              cnt_nxt   = '0;
            end else begin
              cnt_nxt = cnt + 1'b1;
            end
          end
        end

        PLAY: begin
          if (player_goal_i && enemy_goal_i) begin
            // Ambiguous point: nobody scores, re-serve the same way.
            state_nxt = SERVE;
            cnt_nxt   = '0;
          end else if (player_goal_i) begin
            p_score_nxt   = p_score + ONE;
            serve_dir_nxt = 1'b0;
            cnt_nxt       = '0;
            if (p_score + ONE == WIN_VAL) begin
              state_nxt = GAME_OVER;
              won_nxt   = 1'b1;
            end else begin
              state_nxt = SERVE;
            end
          end else if (enemy_goal_i) begin
            e_score_nxt   = e_score + ONE;
            serve_dir_nxt = 1'b1;
            cnt_nxt       = '0;
            if (e_score + ONE == WIN_VAL) begin
              state_nxt = GAME_OVER;
              won_nxt   = 1'b0;
            end else begin
              state_nxt = SERVE;
            end
          end
        end

        GAME_OVER: begin
`ifdef GAME_SCORE_AUTO_RESTART_EN
          // The final tick is handled by restart above.
          if (frame_tick_i) cnt_nxt = cnt + 1'b1;
`endif
        end

        default: begin
          state_nxt = SERVE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst_i) begin
      state     <= SERVE;
      cnt       <= '0;
      p_score   <= '0;
      e_score   <= '0;
      serve_dir <= 1'b0;
      won       <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      p_score   <= p_score_nxt;
      e_score   <= e_score_nxt;
      serve_dir <= serve_dir_nxt;
      won       <= won_nxt;
    end
  end

  assign player_score_o    = p_score;
  assign enemy_score_o     = e_score;
  assign ball_en_o         = (state == PLAY);
  assign game_over_o       = (state == GAME_OVER);
  assign serve_to_player_o = serve_dir;
  assign player_won_o      = won;

endmodule

// File: tb/tb_game_score_keeper.sv
// -----------------------------------------------------------------------------
// tb_game_score_keeper
//   Directed bench for game_score_keeper with WIN_SCORE=9, SERVE_FRAMES=3,
//   RESTART_FRAMES=5. Inputs change on the falling edge and are held for one
//   full clock; outputs are sampled on the following falling edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_game_score_keeper;

  localparam int WIN   = 9;
  localparam int SERVE = 3;
  localparam int RESTART = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick = 1'b0;
  logic       pg = 1'b0;
  logic       eg = 1'b0;
  logic       ng = 1'b0;
  logic [3:0] p_score;
  logic [3:0] e_score;
  logic       ball_en;
  logic       serve_to_player;
  logic       game_over;
  logic       player_won;

  int n_checks = 0;
  int n_fail   = 0;

  game_score_keeper #(
    .WIN_SCORE      (WIN),
    .SERVE_FRAMES   (SERVE),
    .RESTART_FRAMES (RESTART)
  ) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .frame_tick_i      (tick),
    .player_goal_i     (pg),
    .enemy_goal_i      (eg),
    .new_game_i        (ng),
    .player_score_o    (p_score),
    .enemy_score_o     (e_score),
    .ball_en_o         (ball_en),
    .serve_to_player_o (serve_to_player),
    .game_over_o       (game_over),
    .player_won_o      (player_won)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Apply one cycle of inputs, then return on the next falling edge.
  task automatic step(input logic r, input logic t, input logic p,
                      input logic e, input logic n);
    @(negedge clk);
    rst = r; tick = t; pg = p; eg = e; ng = n;
    @(negedge clk);
    rst = 1'b0; tick = 1'b0; pg = 1'b0; eg = 1'b0; ng = 1'b0;
  endtask

  task automatic serve_to_play();
    for (int i = 0; i < SERVE; i++) step(0, 1, 0, 0, 0);
  endtask

  task automatic check_scores(input string tag, input int p, input int e);
    check({tag, "_p"}, int'(p_score), p);
    check({tag, "_e"}, int'(e_score), e);
  endtask

  initial begin
    // Reset state.
    step(1, 0, 0, 0, 0);
    check_scores("reset", 0, 0);
    check("reset_ball", ball_en, 0);
    check("reset_serve", serve_to_player, 0);
    check("reset_over", game_over, 0);
    check("reset_won", player_won, 0);

    // Serve pause: ball enabled only after the third tick.
    step(0, 1, 0, 0, 0);
    check("serve_t1", ball_en, 0);
    step(0, 0, 0, 0, 0);
    check("serve_idle", ball_en, 0);
    step(0, 1, 0, 0, 0);
    check("serve_t2", ball_en, 0);
    step(0, 1, 0, 0, 0);
    check("serve_t3", ball_en, 1);

    // Enemy goal in PLAY.
    step(0, 0, 0, 1, 0);
    check_scores("egoal", 0, 1);
    check("egoal_serve", serve_to_player, 1);
    check("egoal_ball", ball_en, 0);

    // Goals during SERVE are ignored.
    step(0, 1, 1, 0, 0);
    step(0, 0, 0, 1, 0);
    check_scores("serve_goal", 0, 1);
    check("serve_goal_ball", ball_en, 0);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    check("serve_goal_play", ball_en, 1);

    // Simultaneous goals: no score change, direction kept, back to SERVE.
    step(0, 0, 1, 1, 0);
    check_scores("both", 0, 1);
    check("both_serve", serve_to_player, 1);
    check("both_ball", ball_en, 0);
    check("both_over", game_over, 0);

    // Player goal flips the serve direction.
    serve_to_play();
    step(0, 0, 1, 0, 0);
    check_scores("pgoal", 1, 1);
    check("pgoal_serve", serve_to_player, 0);

    // Build 4:7, then new_game together with a player goal in PLAY.
    for (int i = 0; i < 3; i++) begin serve_to_play(); step(0, 0, 1, 0, 0); end
    for (int i = 0; i < 6; i++) begin serve_to_play(); step(0, 0, 0, 1, 0); end
    check_scores("pre_ng", 4, 7);
    serve_to_play();
    check("pre_ng_ball", ball_en, 1);
    step(0, 0, 1, 0, 1);
    check_scores("ng", 0, 0);
    check("ng_ball", ball_en, 0);
    check("ng_serve", serve_to_player, 0);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    check("ng_t2", ball_en, 0);
    step(0, 1, 0, 0, 0);
    check("ng_t3", ball_en, 1);

    // Reset mid-SERVE with counter at 2 restarts the full pause.
    step(0, 0, 1, 0, 0);
    check_scores("pre_rst", 1, 0);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    check_scores("rst_mid", 0, 0);
    check("rst_mid_ball", ball_en, 0);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    check("rst_mid_t2", ball_en, 0);
    step(0, 1, 0, 0, 0);
    check("rst_mid_t3", ball_en, 1);

    // Reset overrides goal and new_game in PLAY.
    step(1, 0, 1, 0, 1);
    check_scores("rst_over", 0, 0);
    check("rst_over_ball", ball_en, 0);

    // Player reaches WIN.
    for (int i = 0; i < WIN; i++) begin serve_to_play(); step(0, 0, 1, 0, 0); end
    check("win_p", int'(p_score), 9);
    check("win_over", game_over, 1);
    check("win_who", player_won, 1);
    check("win_ball", ball_en, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 1, 1, 0);
    check_scores("win_frozen", 9, 0);
    check("win_frozen_over", game_over, 1);

`ifdef GAME_SCORE_AUTO_RESTART_EN
    // Ticks above were already counted (4); one more triggers restart.
    check("auto_t4", game_over, 1);
    step(0, 1, 0, 0, 0);
    check("auto_t5", game_over, 0);
    check_scores("auto", 0, 0);
    check("auto_won", player_won, 0);
    check("auto_ball", ball_en, 0);
`else
    for (int i = 0; i < 1000; i++) step(0, 1, 0, 0, 0);
    check("hold_over", game_over, 1);
    check_scores("hold", 9, 0);
    step(0, 0, 0, 0, 1);
    check("hold_ng_over", game_over, 0);
    check_scores("hold_ng", 0, 0);
`endif

    // Enemy reaches WIN.
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < WIN; i++) begin serve_to_play(); step(0, 0, 0, 1, 0); end
    check_scores("ewin", 0, 9);
    check("ewin_over", game_over, 1);
    check("ewin_who", player_won, 0);
    check("ewin_serve", serve_to_player, 1);
    step(0, 0, 0, 0, 1);
    check("ewin_ng_over", game_over, 0);
    check("ewin_ng_serve", serve_to_player, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
